debug_loader_param: RTL
=======================

Name: debug_loader_param

Overview:
- Byte-serial command decoder between the UART RX/TX pair and the processor core.
- Loads program memory, starts or single-steps the CPU, reads data memory and reports status, all over 8-bit framed commands.
- Generalises the fixed 2-byte-address / 2-byte-instruction loader:
  - field widths are parametrised in bytes;
  - adds STEP, STATUS, a TX reply path, an inter-byte timeout and unknown-opcode handling.

Parameters:
- ADDR_BYTES, 2, bytes per address field; address width AW = 8*ADDR_BYTES.
- INSTR_BYTES, 2, bytes per PM instruction word; IW = 8*INSTR_BYTES.
- DATA_BYTES, 2, bytes per DM word returned by DM_READ; DW = 8*DATA_BYTES.
- TIMEOUT_CYCLES, 100000, max idle cycles between bytes of one frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte.
- rx_done  in  1  rx_data valid; one byte is consumed on every rising clk with rx_done=1.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle pulse; tx_data is valid in that cycle.
- tx_done  in  1  one-cycle pulse from the transmitter when the byte is finished.
- pm_we  out  1  one-cycle program-memory write strobe.
- pm_addr  out  AW  program-memory write address.
- pm_wdata  out  IW  program-memory write data.
- cpu_en  out  1  CPU clock-enable.
- cpu_halted  in  1  CPU has executed HALT.
- cpu_pc  in  AW  current program counter.
- dm_addr  out  AW  data-memory read address.
- dm_rdata  in  DW  data-memory read data, valid one cycle after dm_addr.
- busy  out  1  high in every state except IDLE.
- err_cnt  out  8  saturating count of dropped or invalid frames.

Behaviour:
- Reset: all outputs are 0 and the FSM enters IDLE. Reset mid-frame, mid-run or mid-TX aborts the operation; no partial PM write is issued.
- Byte order: multi-byte fields are little-endian, LSB first. Each byte is shifted into the field register.
- Opcodes are the first byte of a frame, taken in IDLE:
  - 0x01 START
  - 0x02 PM_WRITE
  - 0x03 STEP
  - 0x04 DM_READ
  - 0x05 STATUS
  - any other value is an error.
- FSM states: IDLE, ARGS, PM_WR, RUN, STEP, DM_WAIT, TX_LOAD, TX_WAIT.
- IDLE:
  - PM_WRITE → ARGS, expecting ADDR_BYTES+INSTR_BYTES bytes.
  - DM_READ → ARGS, expecting ADDR_BYTES bytes.
  - START → RUN.
  - STEP → STEP.
  - STATUS → load reply (cpu_pc LSB first, then status byte {7'b0, cpu_halted}) → TX_LOAD.
  - Unknown opcode → err_cnt+1, reply 0xEE.
- ARGS:
  - Counts received bytes; after the last byte, PM_WRITE → PM_WR and DM_READ → DM_WAIT.
  - Inter-byte idle counter resets on each rx_done. When it reaches TIMEOUT_CYCLES (if nonzero), the frame is dropped, err_cnt+1, → IDLE, with no reply.
- PM_WR: pm_we=1 for exactly one cycle with the assembled pm_addr/pm_wdata; reply ack 0x01 → TX_LOAD. Latency: pm_we is asserted in the cycle after the last argument byte is consumed.
- RUN:
  - cpu_en=1 while cpu_halted=0.
  - If cpu_halted=1 on entry, or when it rises: cpu_en=0 in the same cycle, reply 0x01.
  - rx_done bytes received in RUN are ignored.
- STEP: cpu_en=1 for exactly one cycle, then reply 0x01. If the CPU is already halted, cpu_en stays 0 and the reply is 0x01.
- DM_WAIT: dm_addr is driven; one wait cycle; capture dm_rdata; reply DATA_BYTES bytes LSB first.
- TX_LOAD: drive tx_data with the next reply byte, tx_start=1 for one cycle → TX_WAIT.
- TX_WAIT: on tx_done, go to TX_LOAD if bytes remain, else IDLE. rx_done in TX states is ignored.
- tx_start is never re-asserted before tx_done. A tx_done arriving in the same cycle as tx_start is ignored.
- err_cnt saturates at 255.
- pm_addr, pm_wdata and dm_addr hold their last value between operations.

Test Plan:
- PM_WRITE: 0x02,0x00,0x00,0x0F,0x18 on consecutive cycles → one pm_we pulse with pm_addr=0x0000, pm_wdata=0x180F; tx byte 0x01.
- Load 3 words (0x180F @0, 0x0800 @1, 0x0000 @2), then START with cpu_halted asserted 7 cycles later → cpu_en high exactly 7 cycles, then reply 0x01, busy falls after tx_done.
- DM_READ: 0x04,0x00,0x00 with dm_rdata=0x000F → tx bytes 0x0F then 0x00, the second tx_start only after the first tx_done.
- STATUS with cpu_pc=0x0003, cpu_halted=1 → tx bytes 0x03,0x00,0x01. STEP → cpu_en pulse of 1 cycle, reply 0x01.
- Opcode 0x7A → reply 0xEE, err_cnt=1. PM_WRITE stalled after 2 bytes with TIMEOUT_CYCLES=16 → after 16 idle cycles: IDLE, err_cnt=2, no pm_we, no tx.
- reset asserted mid-PM_WRITE (after 3 bytes) and mid-RUN → all outputs 0 next cycle; a fresh full PM_WRITE frame then writes correctly.

Source files
------------

// File: rtl/debug_loader_param_if.sv
// debug_loader_param_if
// Bundles every signal between the debug loader and its surroundings
// (UART RX/TX pair, program memory, data memory, CPU core).
//
// Handshakes:
//   rx_done  : qualifies rx_data; one byte is consumed on every rising clk with rx_done=1.
//              There is no back-pressure, so the loader must accept or discard it.
//   tx_start : one-cycle request; tx_data is valid only in that cycle.
//              Once issued, tx_start is not raised again until the transmitter
//              answers with a one-cycle tx_done.
//   pm_we    : one-cycle write strobe; pm_addr/pm_wdata are valid with it.
//
// master : the loader side.
// slave  : the environment side (UART, memories, CPU).
interface debug_loader_param_if #(
  parameter int AW = 16,
  parameter int IW = 16,
  parameter int DW = 16
) ();
  logic [7:0]    rx_data;
  logic          rx_done;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [IW-1:0] pm_wdata;
  logic          cpu_en;
  logic          cpu_halted;
  logic [AW-1:0] cpu_pc;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_rdata;
  logic          busy;
  logic [7:0]    err_cnt;

  modport master (
    input  rx_data, rx_done, tx_done, cpu_halted, cpu_pc, dm_rdata,
    output tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, dm_addr, busy, err_cnt
  );

  modport slave (
    output rx_data, rx_done, tx_done, cpu_halted, cpu_pc, dm_rdata,
    input  tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, dm_addr, busy, err_cnt
  );
endinterface

// File: rtl/debug_loader_param.sv
// debug_loader_param
// Byte-serial command decoder sitting between the UART and the CPU core.
// The first byte of a frame is the opcode:
//   0x01 START, 0x02 PM_WRITE, 0x03 STEP, 0x04 DM_READ, 0x05 STATUS.
// Any other opcode replies 0xEE.
// Multi-byte fields are little-endian.
//
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : debug_loader_param_if.master (UART, PM, DM and CPU signals)
//   state_dbg  : current FSM state, for observation only
module debug_loader_param #(
  parameter int ADDR_BYTES     = 2,
  parameter int INSTR_BYTES    = 2,
  parameter int DATA_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  debug_loader_param_if.master bus,
  output logic [2:0]           state_dbg
);
  localparam int AW        = 8 * ADDR_BYTES;
  localparam int IW        = 8 * INSTR_BYTES;
  localparam int DW        = 8 * DATA_BYTES;
  localparam int ARG_BYTES = ADDR_BYTES + INSTR_BYTES;
  localparam int ARG_W     = 8 * ARG_BYTES;
  // The longest reply is either STATUS (pc + status byte) or DM_READ (data word).
  localparam int RPL_BYTES = (ADDR_BYTES + 1 > DATA_BYTES) ? ADDR_BYTES + 1 : DATA_BYTES;
  localparam int RW        = 8 * RPL_BYTES;
  localparam int CW        = $clog2(ARG_BYTES + 1);
  localparam int LW        = $clog2(RPL_BYTES + 1);
  localparam int TW        = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARGS    = 3'd1;
  localparam logic [2:0] S_PM_WR   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_STEP    = 3'd4;
  localparam logic [2:0] S_DM_WAIT = 3'd5;
  localparam logic [2:0] S_TX_LOAD = 3'd6;
  localparam logic [2:0] S_TX_WAIT = 3'd7;

  localparam logic [7:0] OP_START    = 8'h01;
  localparam logic [7:0] OP_PM_WRITE = 8'h02;
  localparam logic [7:0] OP_STEP     = 8'h03;
  localparam logic [7:0] OP_DM_READ  = 8'h04;
  localparam logic [7:0] OP_STATUS   = 8'h05;
  localparam logic [7:0] RPL_ACK     = 8'h01;
  localparam logic [7:0] RPL_NAK     = 8'hEE;

  logic [2:0]       state_q, state_d;
  logic             is_pm_q, is_pm_d;     // frame in ARGS is PM_WRITE (else DM_READ)
  logic [CW-1:0]    cnt_q, cnt_d;         // argument bytes received so far
  logic [TW-1:0]    idle_q, idle_d;       // idle cycles since last argument byte
  logic [ARG_W-1:0] arg_q, arg_d;
  logic [AW-1:0]    pm_addr_q, pm_addr_d;
  logic [IW-1:0]    pm_wdata_q, pm_wdata_d;
  logic [AW-1:0]    dm_addr_q, dm_addr_d;
  logic             wait_q, wait_d;       // DM read latency cycle elapsed
  logic [RW-1:0]    reply_q, reply_d;     // reply bytes, next one in [7:0]
  logic [LW-1:0]    left_q, left_d;       // reply bytes still to send after the current one
  logic [7:0]       err_q, err_d;
  logic             err_inc;
  logic             last_arg;

  assign last_arg = (cnt_q == (is_pm_q ? CW'(ARG_BYTES - 1) : CW'(ADDR_BYTES - 1)));

  always_comb begin
    state_d    = state_q;
    is_pm_d    = is_pm_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    arg_d      = arg_q;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    dm_addr_d  = dm_addr_q;
    wait_d     = wait_q;
    reply_d    = reply_q;
    left_d     = left_q;
    err_inc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_done) begin
          cnt_d  = '0;
          idle_d = '0;
          case (bus.rx_data)
            OP_START:    state_d = S_RUN;
            OP_STEP:     state_d = S_STEP;
            OP_PM_WRITE: begin
              is_pm_d = 1'b1;
              state_d = S_ARGS;
            end
            OP_DM_READ: begin
              is_pm_d = 1'b0;
              state_d = S_ARGS;
            end
            OP_STATUS: begin
              reply_d          = '0;
              reply_d[AW-1:0]  = bus.cpu_pc;
              reply_d[AW +: 8] = {7'b0, bus.cpu_halted};
              left_d           = LW'(ADDR_BYTES);
              state_d          = S_TX_LOAD;
            end
            default: begin
              err_inc = 1'b1;
              reply_d = RW'(RPL_NAK);
              left_d  = '0;
              state_d = S_TX_LOAD;
            end
          endcase
        end
      end

      S_ARGS: begin
        if (bus.rx_done) begin
          arg_d[{cnt_q, 3'b000} +: 8] = bus.rx_data;
          idle_d = '0;
          cnt_d  = cnt_q + 1'b1;
          if (last_arg) begin
            // arg_d already holds the final byte, so the fields are complete here.
            if (is_pm_q) begin
              pm_addr_d  = arg_d[AW-1:0];
              pm_wdata_d = arg_d[AW +: IW];
              state_d    = S_PM_WR;
            end else begin
              dm_addr_d = arg_d[AW-1:0];
              wait_d    = 1'b0;
              state_d   = S_DM_WAIT;
            end
          end
        end else if (TIMEOUT_CYCLES != 0 && idle_q == TO_LAST) begin
          // Stalled frame: drop it silently, only the error counter records it.
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      S_PM_WR, S_STEP: begin
        reply_d = RW'(RPL_ACK);
        left_d  = '0;
        state_d = S_TX_LOAD;
      end

      S_RUN: begin
        if (bus.cpu_halted) begin
          reply_d = RW'(RPL_ACK);
          left_d  = '0;
          state_d = S_TX_LOAD;
        end
      end

      S_DM_WAIT: begin
        // First cycle presents dm_addr; dm_rdata is valid on the second.
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          reply_d         = '0;
          reply_d[DW-1:0] = bus.dm_rdata;
          left_d          = LW'(DATA_BYTES - 1);
          state_d         = S_TX_LOAD;
        end
      end

      S_TX_LOAD: state_d = S_TX_WAIT;

      S_TX_WAIT: begin
        // Entered one cycle after tx_start, so a tx_done coincident with tx_start is never seen.
        if (bus.tx_done) begin
          if (left_q != '0) begin
            left_d  = left_q - 1'b1;
            reply_d = reply_q >> 8;
            state_d = S_TX_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_pm_q    <= 1'b0;
      cnt_q      <= '0;
      idle_q     <= '0;
      arg_q      <= '0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      dm_addr_q  <= '0;
      wait_q     <= 1'b0;
      reply_q    <= '0;
      left_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_pm_q    <= is_pm_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      arg_q      <= arg_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      dm_addr_q  <= dm_addr_d;
      wait_q     <= wait_d;
      reply_q    <= reply_d;
      left_q     <= left_d;
      err_q      <= err_d;
    end
  end

  assign bus.tx_data  = (state_q == S_TX_LOAD) ? reply_q[7:0] : 8'h00;
  assign bus.tx_start = (state_q == S_TX_LOAD);
  assign bus.pm_we    = (state_q == S_PM_WR);
  assign bus.pm_addr  = pm_addr_q;
  assign bus.pm_wdata = pm_wdata_q;
  // Clock enable drops combinationally in the very cycle cpu_halted rises.
  assign bus.cpu_en   = (state_q == S_RUN || state_q == S_STEP) && !bus.cpu_halted;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.err_cnt  = err_q;
  assign state_dbg    = state_q;
endmodule
